// File: rtl/fifo_pkg.sv
// Constants shared by both ends of the 7-entry shift FIFO, plus the UART drain FSM state type.
`timescale 1ns/1ps
package fifo_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 7;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_e;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the terminal count.
`timescale 1ns/1ps
module baud_tick_gen #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_BITS = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(CLKS_PER_BIT - 1);

  logic [CNT_BITS-1:0] cnt_q;

  assign tick = (cnt_q == LAST) && !clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain and 8N1 UART transmitter: tracks FIFO fill, pops a byte when present, sends it LSB first.
`timescale 1ns/1ps
module fifo_uart_tx
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W       = fifo_pkg::DATA_W,
  parameter int unsigned DEPTH        = fifo_pkg::DEPTH,
  parameter int unsigned CNT_W        = fifo_pkg::CNT_W,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_wr_seen,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              tx,
  output logic              busy,
  output logic [CNT_W-1:0]  occupancy
);

  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] OCC_FULL = CNT_W'(DEPTH);

  tx_state_e         state_q;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic [DATA_W-1:0] shreg_q;
  logic [BIT_W-1:0]  bit_idx_q;
  logic              tx_q, busy_q, rd_en_q;
  logic              tick, timer_clear;

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign occupancy  = occ_q;

  // Mirror of the FIFO tail index; a write at full is dropped unless a pop frees a slot.
  always_comb begin
    occ_d = occ_q;
    if (fifo_wr_seen && !rd_en_q) begin
      if (occ_q != OCC_FULL) begin
        occ_d = occ_q + CNT_W'(1);
      end
    end else if (!fifo_wr_seen && rd_en_q && (occ_q != '0)) begin
      occ_d = occ_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign timer_clear = (state_q == LOAD);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clear(timer_clear),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      shreg_q   <= '0;
      bit_idx_q <= '0;
    end else begin
      rd_en_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (occ_q != '0) begin
            state_q <= POP;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        POP: begin
          state_q <= LOAD;
        end
        LOAD: begin
          shreg_q   <= fifo_data;
          bit_idx_q <= '0;
          tx_q      <= 1'b0;
          state_q   <= START;
        end
        START: begin
          if (tick) begin
            tx_q    <= shreg_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx_q == LAST_BIT) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              // Next bit goes out from shreg[1], which becomes shreg[0] after the shift.
              shreg_q   <= shreg_q >> 1;
              tx_q      <= shreg_q[1];
              bit_idx_q <= bit_idx_q + BIT_W'(1);
            end
          end
        end
        STOP: begin
          if (tick) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Drain side of the 7-entry, 8-bit shift FIFO. Tracks FIFO occupancy from the write strobes it sees and its own read pulses, and pops one byte whenever data is present. Serialises each byte onto the Arty-7 USB-UART line as 8N1, LSB first. Sits between the FIFO's read port and the board `uart_rxd_out` pin.

## Interface
Parameters:
- `DATA_W`, 8, byte width; must equal the FIFO bit depth.
- `DEPTH`, 7, FIFO capacity in entries.
- `CNT_W`, 3, occupancy counter width; holds 0..`DEPTH`.
- `CLKS_PER_BIT`, 868, clk cycles per UART bit (100 MHz / 115200).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `fifo_wr_seen`  in  1  copy of the FIFO `enable_write` strobe.
- `fifo_rd_en`  out  1  one-cycle pop pulse to the FIFO `enable_read`.
- `fifo_data`  in  `DATA_W`  FIFO `value_to_read`; valid the cycle after `fifo_rd_en`.
- `tx`  out  1  UART serial output, idle high.
- `busy`  out  1  high from POP through the end of STOP.
- `occupancy`  out  `CNT_W`  tracked FIFO fill level, debug only.

## Operation
Occupancy counter `occ` (mirrors the FIFO tail index):
- Write only: `occ+1` if `occ<DEPTH`. At `DEPTH` the write is dropped by the FIFO, so `occ` holds.
- Pop only: `occ-1`.
- Write and pop in the same cycle: `occ` unchanged.
- A pop is never issued when `occ==0`. The FIFO's read-plus-write-at-empty path is therefore never exercised.

FSM states:
- IDLE: `tx=1`, `busy=0`. Go to POP when `occ!=0`.
- POP: `fifo_rd_en=1` for exactly this cycle. Go to LOAD.
- LOAD: capture `fifo_data` into `shreg` at the end of this cycle. Clear the bit timer. Go to START.
- START: `tx=0` for `CLKS_PER_BIT` cycles. Go to DATA.
- DATA: `tx=shreg[0]` for `CLKS_PER_BIT` cycles per bit, shifting right after each bit. Bit index runs 0..7. After bit 7, go to STOP.
- STOP: `tx=1` for `CLKS_PER_BIT` cycles. Go to IDLE.

Further rules:
- Bit timer counts 0..`CLKS_PER_BIT-1`. A terminal count advances the bit or state. Timer width is `$clog2(CLKS_PER_BIT)`.
- `fifo_wr_seen` is sampled in every state, so writes arriving during a frame are counted.
- Reset values: state IDLE, `occ=0`, `tx=1`, `fifo_rd_en=0`, `busy=0`, `shreg=0`, timer 0, bit index 0.
- Reset mid-frame: `tx` returns high immediately (asynchronous). The partial frame is abandoned and `occ` is cleared. The FIFO is reset by the same `rst`, so the two stay consistent.

## Timing
- Pop latency: `occ` goes nonzero at edge E. POP is the cycle after E, and `fifo_rd_en` is high in that cycle.
- Data: `fifo_data` is registered by the FIFO on the POP edge and captured in LOAD.
- First start-bit cycle is 3 cycles after `occ` goes nonzero.
- Frame length: START through STOP is exactly `10*CLKS_PER_BIT` cycles.
- Back-to-back bytes: last STOP cycle → IDLE (1) → POP (1) → LOAD (1) → START. Inter-frame gap is 3 cycles of `tx=1` beyond the stop bit.
- `fifo_rd_en` is never high for two consecutive cycles. It is never high unless `occ>=1` in that cycle.
- `occ` saturates at `DEPTH` and never wraps below 0.

## Structure
- Shared package `fifo_pkg` holds `DATA_W=8`, `DEPTH=7`, `CNT_W=3`. These are the same constants as the FIFO, so both ends agree.
- Package also holds the FSM state enum: IDLE, POP, LOAD, START, DATA, STOP.
- One sub-module, `baud_tick_gen`:
  - Parameter `CLKS_PER_BIT`; inputs `clk`, `rst`, `clear`; output `tick`.
  - `tick` pulses on terminal count. `clear` is asserted in LOAD.
- FSM, occupancy counter and shift register stay in the top module.

## Test plan
All scenarios use `CLKS_PER_BIT=4`, with the real FIFO instance connected.
- Single byte: write 0xA5 once → `fifo_rd_en` pulses 2 cycles later. `tx` shows 0, 1,0,1,0,0,1,0,1, 1, each bit 4 cycles, 40 cycles total. `occ` returns to 0.
- Burst fill: write 0x01..0x07 on 7 consecutive cycles → `occ` reaches 6 or 7 depending on the pop overlap. Seven frames 0x01..0x07 appear in order with 3-cycle gaps.
- Overflow: while `tx` is in frame 1, write 9 more bytes with `occ` already 6 → `occ` saturates at 7. Excess writes are dropped, and exactly `DEPTH+1` frames total are emitted in order.
- Simultaneous write and pop: with `occ=2`, assert `fifo_wr_seen` in the POP cycle → `occ` stays 2. No byte is lost or duplicated.
- Empty guard: no writes for 100 cycles after reset → `fifo_rd_en` stays 0, `tx` stays 1, `busy` stays 0.
- Reset mid-frame: assert `rst` during DATA bit 3 → `tx=1` in the same cycle, `occ=0`, `busy=0`. After release, a new write of 0x3C transmits correctly.
